// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline sequencing controller for the 5-stage RV32I core.
//
// This block sits beside the decode stage. It keeps a shadow copy of the
// destination register of each instruction that is in EX and MEM. From
// these copies it drives the IF/ID stall, inserts a bubble into EX, squashes
// the fetch on a taken branch, and selects forwarding for the EX operand muxes.
// It also keeps two saturating counters: stall cycles and flush cycles.
//
// Build option: define HAZARD_FWD_EN to enable operand forwarding.
//   defined   : only a load-use hazard against EX stalls, for exactly one
//               cycle. ALU results are forwarded from EX/MEM (10). Load data
//               is forwarded from MEM/WB (01).
//   undefined : any producer in EX or MEM stalls until it reaches WB.
//               fwd_a_sel and fwd_b_sel are tied to 00.
//
// Ports
//   clk, rst_n                  clock and asynchronous active-low reset
//   id_valid                    ID holds a valid instruction
//   id_rs1/rs2, id_use_rs1/rs2  source fields and their use flags
//   id_rd, id_regwrite          destination of the ID instruction
//   id_memread                  non-zero = load
//   ex_taken                    branch/jump in EX resolved taken
//   stall_if, stall_id          hold PC and IF/ID (combinational)
//   bubble_ex, flush_if         NOP into ID/EX and IF/ID (combinational)
//   fwd_a_sel, fwd_b_sel        EX operand source, registered
//   ctrl_state                  00 RUN, 01 STALL, 10 FLUSH
//   stall_cnt, flush_cnt        saturating performance counters
//
// State  | meaning
// RUN    | last cycle had no hazard and no taken branch
// STALL  | last cycle held IF/ID and bubbled EX
// FLUSH  | last cycle squashed the fetch for a taken branch/jump
module hazard_ctrl #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [4:0]       id_rd,
    input  logic             id_regwrite,
    input  logic [1:0]       id_memread,
    input  logic             ex_taken,
    output logic             stall_if,
    output logic             stall_id,
    output logic             bubble_ex,
    output logic             flush_if,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_STALL = 2'b01,
        ST_FLUSH = 2'b10
    } state_t;

    state_t state_q, state_d;

    // Shadow pipeline. The WB stage is not kept: the register file writes
    // through, so a producer in WB never needs a stall or a forward.
    logic       ex_valid_q, ex_regwrite_q, ex_load_q;
    logic [4:0] ex_rd_q;
    logic       mem_valid_q, mem_regwrite_q;
    logic [4:0] mem_rd_q;

    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic m_ex1, m_ex2, m_mem1, m_mem2;
    logic hazard, ex_bubble, stall_inc;

    function automatic logic dep(input logic rd_use, input logic [4:0] rs,
                                 input logic v, input logic rw,
                                 input logic [4:0] rd);
        return rd_use & v & rw & (rd == rs) & (rs != 5'd0);
    endfunction

    assign m_ex1  = dep(id_use_rs1, id_rs1, ex_valid_q, ex_regwrite_q, ex_rd_q);
    assign m_ex2  = dep(id_use_rs2, id_rs2, ex_valid_q, ex_regwrite_q, ex_rd_q);
    assign m_mem1 = dep(id_use_rs1, id_rs1, mem_valid_q, mem_regwrite_q, mem_rd_q);
    assign m_mem2 = dep(id_use_rs2, id_rs2, mem_valid_q, mem_regwrite_q, mem_rd_q);

`ifdef HAZARD_FWD_EN
    assign hazard = id_valid & ex_load_q & (m_ex1 | m_ex2);
`else
    logic load_unused;
    assign load_unused = ex_load_q;
    assign hazard = id_valid & (m_ex1 | m_ex2 | m_mem1 | m_mem2);
`endif

    // A taken branch wins over a hazard. The squashed ID instruction must not
    // reach EX, so a bubble is inserted in both cases.
    assign ex_bubble = ex_taken | hazard;
    assign stall_inc = hazard & ~ex_taken;

    // The outputs are gated by rst_n so that they drop at once while reset is low.
    always_comb begin
        stall_if  = 1'b0;
        stall_id  = 1'b0;
        bubble_ex = 1'b0;
        flush_if  = 1'b0;
        if (rst_n) begin
            if (ex_taken) begin
                flush_if  = 1'b1;
                bubble_ex = 1'b1;
            end else if (hazard) begin
                stall_if  = 1'b1;
                stall_id  = 1'b1;
                bubble_ex = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_valid_q     <= 1'b0;
            ex_rd_q        <= 5'd0;
            ex_regwrite_q  <= 1'b0;
            ex_load_q      <= 1'b0;
            mem_valid_q    <= 1'b0;
            mem_rd_q       <= 5'd0;
            mem_regwrite_q <= 1'b0;
        end else begin
            ex_valid_q     <= id_valid & ~ex_bubble;
            ex_rd_q        <= id_rd;
            ex_regwrite_q  <= id_regwrite;
            ex_load_q      <= |id_memread;
            mem_valid_q    <= ex_valid_q;
            mem_rd_q       <= ex_rd_q;
            mem_regwrite_q <= ex_regwrite_q;
        end
    end

`ifdef HAZARD_FWD_EN
    // The select is computed while the consumer is still in ID. When the
    // consumer moves into EX, the current EX producer moves into EX/MEM (10)
    // and the current MEM producer moves into MEM/WB (01).
    logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;

    always_comb begin
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (!ex_bubble) begin
            if (m_ex1 & ~ex_load_q) fwd_a_d = 2'b10;
            else if (m_mem1)        fwd_a_d = 2'b01;
            if (m_ex2 & ~ex_load_q) fwd_b_d = 2'b10;
            else if (m_mem2)        fwd_b_d = 2'b01;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_a_q <= 2'b00;
            fwd_b_q <= 2'b00;
        end else begin
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    assign fwd_a_sel = fwd_a_q;
    assign fwd_b_sel = fwd_b_q;
`else
    assign fwd_a_sel = 2'b00;
    assign fwd_b_sel = 2'b00;
`endif

    always_comb begin
        state_d = ST_RUN;
        if (ex_taken)    state_d = ST_FLUSH;
        else if (hazard) state_d = ST_STALL;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_RUN;
        else        state_q <= state_d;
    end

    assign ctrl_state = state_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (stall_inc && (stall_cnt_q != {CNT_W{1'b1}}))
                stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
            if (ex_taken && (flush_cnt_q != {CNT_W{1'b1}}))
                flush_cnt_q <= flush_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule
